// File: rtl/keypad_scan_controller.sv
// rtl/keypad_scan_controller.sv - 4x4 matrix keypad scanner with press/release debounce
//
// Drives one keypad column at a time and classifies the synchronized rows
// sampled at the end of every column slot. A key is accepted after
// DEBOUNCE_SLOTS consecutive matching slots and released after the same
// number of empty slots. One key_valid strobe is issued per physical press.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-high reset
//   rows_n     keypad rows, active-low, asynchronous to clk
//   cols_n     column drive, active-low one-hot
//   key_code   {row_idx, col_idx} of the last accepted key
//   key_valid  one-cycle strobe when key_code is updated
//   key_held   high from acceptance until release is debounced
module keypad_scan_controller #(
    parameter int SCAN_DIV       = 4,
    parameter int DEBOUNCE_SLOTS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows_n,
    output logic [3:0] cols_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DIV_W = $clog2(SCAN_DIV) + 1;
    localparam int DB_W  = $clog2(DEBOUNCE_SLOTS) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]  DB_TGT   = DB_W'(DEBOUNCE_SLOTS);
    localparam logic [DB_W-1:0]  DB_ONE   = DB_W'(1);

    typedef enum logic [1:0] {
        SCAN       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    state_t          state, state_nx;
    logic [3:0]      rows_s1, rows_s2;
    logic [DIV_W-1:0] div_cnt;
    logic            tick;
    logic [1:0]      col_idx, col_nx;
    logic [1:0]      row_idx, row_nx;
    logic [DB_W-1:0] db_cnt, db_nx, db_inc;
    logic [3:0]      code_nx;
    logic            valid_nx, held_nx;
    logic            single, none;
    logic [1:0]      row_enc;

    // Rows are inverted at the pin so that a pressed key reads as 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rows_s1 <= 4'b0000;
            rows_s2 <= 4'b0000;
        end else begin
            rows_s1 <= ~rows_n;
            rows_s2 <= rows_s1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign tick   = (div_cnt == DIV_LAST);
    assign none   = (rows_s2 == 4'b0000);
    assign db_inc = db_cnt + DB_ONE;
    assign cols_n = ~(4'b0001 << col_idx);

    always_comb begin
        single  = 1'b1;
        row_enc = 2'd0;
        case (rows_s2)
            4'b0001: row_enc = 2'd0;
            4'b0010: row_enc = 2'd1;
            4'b0100: row_enc = 2'd2;
            4'b1000: row_enc = 2'd3;
            default: single  = 1'b0;
        endcase
    end

    always_comb begin
        state_nx = state;
        col_nx   = col_idx;
        row_nx   = row_idx;
        db_nx    = db_cnt;
        code_nx  = key_code;
        held_nx  = key_held;
        valid_nx = 1'b0;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (single) begin
                        row_nx = row_enc;
                        db_nx  = DB_ONE;
                        // A single-slot debounce accepts on the detecting tick.
                        if (DB_TGT == DB_ONE) begin
                            state_nx = HELD;
                            code_nx  = {row_enc, col_idx};
                            valid_nx = 1'b1;
                            held_nx  = 1'b1;
                        end else begin
                            state_nx = PRESS_DB;
                        end
                    end else begin
                        col_nx = col_idx + 2'd1;
                    end
                end
                PRESS_DB: begin
                    if (single && (row_enc == row_idx)) begin
                        db_nx = db_inc;
                        if (db_inc == DB_TGT) begin
                            state_nx = HELD;
                            code_nx  = {row_idx, col_idx};
                            valid_nx = 1'b1;
                            held_nx  = 1'b1;
                        end
                    end else begin
                        db_nx    = '0;
                        col_nx   = col_idx + 2'd1;
                        state_nx = SCAN;
                    end
                end
                HELD: begin
                    // Extra rows on the frozen column never produce a second key.
                    if (none) begin
                        db_nx = DB_ONE;
                        if (DB_TGT == DB_ONE) begin
                            db_nx    = '0;
                            held_nx  = 1'b0;
                            col_nx   = col_idx + 2'd1;
                            state_nx = SCAN;
                        end else begin
                            state_nx = RELEASE_DB;
                        end
                    end
                end
                RELEASE_DB: begin
                    if (none) begin
                        db_nx = db_inc;
                        if (db_inc == DB_TGT) begin
                            db_nx    = '0;
                            held_nx  = 1'b0;
                            col_nx   = col_idx + 2'd1;
                            state_nx = SCAN;
                        end
                    end else begin
                        db_nx    = '0;
                        state_nx = HELD;
                    end
                end
                default: state_nx = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SCAN;
            col_idx   <= 2'd0;
            row_idx   <= 2'd0;
            db_cnt    <= '0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_nx;
            col_idx   <= col_nx;
            row_idx   <= row_nx;
            db_cnt    <= db_nx;
            key_code  <= code_nx;
            key_valid <= valid_nx;
            key_held  <= held_nx;
        end
    end

endmodule

// File: tb/tb_keypad_scan_controller.sv
// tb/tb_keypad_scan_controller.sv - directed self-checking bench for keypad_scan_controller
module tb_keypad_scan_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] rows_n = 4'b1111;
    logic [3:0] cols_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    int   n_err = 0;
    int   n_chk = 0;
    int   valid_cnt = 0;
    logic last_valid = 1'b0;

    localparam logic [3:0] COLS [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    keypad_scan_controller #(.SCAN_DIV(4), .DEBOUNCE_SLOTS(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .rows_n    (rows_n),
        .cols_n    (cols_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        last_valid = key_valid;
        if (key_valid) valid_cnt++;
    endtask

    // One column slot; the final sample is taken just after the tick edge.
    task automatic slot();
        repeat (4) cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_cols", {4'h0, cols_n}, 8'h0E);
        check("rst_code", {4'h0, key_code}, 8'h00);
        check("rst_valid", {7'h0, key_valid}, 8'h00);
        check("rst_held", {7'h0, key_held}, 8'h00);
        @(negedge clk);
        reset = 1'b0;

        // 1: idle scan, 40 clocks
        for (int k = 0; k < 10; k++) begin
            slot();
            check($sformatf("t1_col%0d", k), {4'h0, cols_n}, {4'h0, COLS[(k + 1) % 4]});
        end
        check("t1_valid", 8'(valid_cnt), 8'd0);

        // 3: one-tick bounce on column 2
        rows_n = 4'b1101;
        slot();
        check("t3_frozen", {4'h0, cols_n}, 8'h0B);
        rows_n = 4'b1111;
        slot();
        check("t3_adv", {4'h0, cols_n}, 8'h07);
        check("t3_valid", 8'(valid_cnt), 8'd0);
        repeat (3) slot();
        check("t3_back_col2", {4'h0, cols_n}, 8'h0B);

        // 2: clean press of row 1 on column 2
        rows_n = 4'b1101;
        slot();
        check("t2_frozen", {4'h0, cols_n}, 8'h0B);
        check("t2_held_early", {7'h0, key_held}, 8'h00);
        slot();
        check("t2_no_valid_yet", 8'(valid_cnt), 8'd0);
        slot();
        check("t2_valid", {7'h0, last_valid}, 8'h01);
        check("t2_code", {4'h0, key_code}, 8'h06);
        check("t2_held", {7'h0, key_held}, 8'h01);
        check("t2_cols", {4'h0, cols_n}, 8'h0B);

        // 4: release bounce, then clean release
        rows_n = 4'b1111;
        slot();
        check("t4_bounce_held", {7'h0, key_held}, 8'h01);
        rows_n = 4'b1101;
        slot();
        check("t4_repress_held", {7'h0, key_held}, 8'h01);
        check("t4_repress_cols", {4'h0, cols_n}, 8'h0B);
        rows_n = 4'b1111;
        slot();
        slot();
        check("t4_rel2_held", {7'h0, key_held}, 8'h01);
        slot();
        check("t4_rel3_held", {7'h0, key_held}, 8'h00);
        check("t4_cols", {4'h0, cols_n}, 8'h07);
        check("t4_code_kept", {4'h0, key_code}, 8'h06);
        check("t4_one_valid", 8'(valid_cnt), 8'd1);

        // 5: two rows at once is never a key
        rows_n = 4'b1100;
        for (int k = 0; k < 4; k++) begin
            slot();
            check($sformatf("t5_col%0d", k), {4'h0, cols_n}, {4'h0, COLS[k]});
        end
        check("t5_valid", 8'(valid_cnt), 8'd1);
        check("t5_held", {7'h0, key_held}, 8'h00);

        // 6: press row 0 on column 3, then reset while held
        rows_n = 4'b1110;
        repeat (3) slot();
        check("t6_valid", 8'(valid_cnt), 8'd2);
        check("t6_code", {4'h0, key_code}, 8'h03);
        check("t6_held", {7'h0, key_held}, 8'h01);
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_cols", {4'h0, cols_n}, 8'h0E);
        check("t6_rst_held", {7'h0, key_held}, 8'h00);
        check("t6_rst_code", {4'h0, key_code}, 8'h00);
        check("t6_rst_valid", {7'h0, key_valid}, 8'h00);
        rows_n = 4'b1111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        slot();
        check("t6_restart1", {4'h0, cols_n}, 8'h0D);
        slot();
        check("t6_restart2", {4'h0, cols_n}, 8'h0B);
        check("t6_valid_total", 8'(valid_cnt), 8'd2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
